// File: rtl/cook_timer.sv
// Countdown cook timer: keypad mm:ss BCD entry, start/stop/clear buttons, door interlock.
// Counts down once per TICKS_PER_SEC cycles while the magnetron is reported on.
module cook_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned PS_W          = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        clearn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        door_closed,
    input  logic        magnet_on,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        timer_done
);

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [PS_W-1:0] PsLast = PS_W'(TICKS_PER_SEC - 1);

    state_e          state_q, state_d;
    logic [15:0]     time_q, time_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            running_q, done_q;
    logic [15:0]     time_dec;

    // One-second BCD decrement; caller guarantees time_q != 0.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m_hi, m_lo, s_hi, s_lo;
        logic       borrow;
        {m_hi, m_lo, s_hi, s_lo} = t;
        borrow = (s_lo == 4'd0);
        s_lo   = borrow ? 4'd9 : s_lo - 4'd1;
        if (borrow) begin
            borrow = (s_hi == 4'd0);
            s_hi   = borrow ? 4'd5 : s_hi - 4'd1;
        end
        if (borrow) begin
            borrow = (m_lo == 4'd0);
            m_lo   = borrow ? 4'd9 : m_lo - 4'd1;
        end
        if (borrow) begin
            m_hi = m_hi - 4'd1;
        end
        return {m_hi, m_lo, s_hi, s_lo};
    endfunction

    assign time_dec = bcd_dec(time_q);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        ps_d    = ps_q;
        // Each event level consumes the cycle; a tick only happens when nothing above it fired.
        if (!clearn) begin
            state_d = StIdle;
            time_d  = 16'h0000;
            ps_d    = '0;
        end else if (!stopn) begin
            case (state_q)
                StRun: state_d = StPause;
                StSet, StPause: begin
                    state_d = StIdle;
                    time_d  = 16'h0000;
                    ps_d    = '0;
                end
                default: ;
            endcase
        end else if (!door_closed) begin
            if (state_q == StRun) begin
                state_d = StPause;
            end
        end else if (state_q == StRun) begin
            if (magnet_on) begin
                if (ps_q == PsLast) begin
                    ps_d = '0;
                    if (time_q != 16'h0000) begin
                        time_d = time_dec;
                        if (time_dec == 16'h0000) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
        end else if (!startn) begin
            if ((state_q == StSet || state_q == StPause) && time_q != 16'h0000) begin
                state_d = StRun;
            end
        end else if (digit_valid && digit <= 4'd9) begin
            if (state_q == StIdle || state_q == StSet || state_q == StDone) begin
                time_d  = {time_q[11:0], digit};
                state_d = StSet;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            time_q    <= 16'h0000;
            ps_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            ps_q      <= ps_d;
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StDone);
        end
    end

    assign time_bcd   = time_q;
    assign running    = running_q;
    assign timer_done = done_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICKS_PER_SEC = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cook_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clearn, startn, stopn, door_closed, magnet_on;
    logic [15:0] time_bcd;
    logic        running, timer_done;

    int tests  = 0;
    int errors = 0;

    cook_timer #(
        .TICKS_PER_SEC(4),
        .PS_W         (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_valid(digit_valid),
        .digit      (digit),
        .clearn     (clearn),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .magnet_on  (magnet_on),
        .time_bcd   (time_bcd),
        .running    (running),
        .timer_done (timer_done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        cyc(1);
        digit_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        cyc(1);
        startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        cyc(1);
        stopn = 1'b1;
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        cyc(1);
        clearn = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; digit_valid = 1'b0; digit = 4'd0;
        clearn = 1'b1; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; magnet_on = 1'b0;
        cyc(2);
        rst = 1'b0;
        tests++;
        if ({time_bcd, running, timer_done} !== 18'h0) begin
            errors++;
            $display("FAIL reset: time=%h run=%b done=%b want 0000/0/0", time_bcd, running,
                     timer_done);
        end
    endtask

    task automatic test_countdown();
        press_digit(4'd0); press_digit(4'd0); press_digit(4'd0); press_digit(4'd3);
        tests++;
        if (time_bcd !== 16'h0003) begin
            errors++; $display("FAIL entry_0003: got %h want 0003", time_bcd);
        end
        magnet_on = 1'b1;
        press_start();
        tests++;
        if (running !== 1'b1 || time_bcd !== 16'h0003) begin
            errors++; $display("FAIL start_run: run=%b time=%h want 1/0003", running, time_bcd);
        end
        cyc(3);
        tests++;
        if (time_bcd !== 16'h0003) begin
            errors++; $display("FAIL pre_tick: got %h want 0003", time_bcd);
        end
        cyc(1);
        tests++;
        if (time_bcd !== 16'h0002) begin
            errors++; $display("FAIL tick1: got %h want 0002", time_bcd);
        end
        cyc(4);
        tests++;
        if (time_bcd !== 16'h0001) begin
            errors++; $display("FAIL tick2: got %h want 0001", time_bcd);
        end
        cyc(3);
        tests++;
        if (timer_done !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL pre_done: done=%b run=%b want 0/1", timer_done, running);
        end
        cyc(1);
        tests++;
        if (time_bcd !== 16'h0000) begin
            errors++; $display("FAIL tick3: got %h want 0000", time_bcd);
        end
        cyc(1);
        tests++;
        if (timer_done !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL done: done=%b run=%b want 1/0", timer_done, running);
        end
        cyc(7);
        press_start();
        tests++;
        if (timer_done !== 1'b1 || running !== 1'b0 || time_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL done_held: done=%b run=%b time=%h want 1/0/0000", timer_done,
                     running, time_bcd);
        end
        press_digit(4'd1);
        tests++;
        if (timer_done !== 1'b0 || time_bcd !== 16'h0001) begin
            errors++; $display("FAIL done_exit: done=%b time=%h want 0/0001", timer_done, time_bcd);
        end
        press_clear();
    endtask

    task automatic test_borrow();
        press_digit(4'd1); press_digit(4'd0); press_digit(4'd0);
        press_start();
        cyc(4);
        tests++;
        if (time_bcd !== 16'h0059) begin
            errors++; $display("FAIL borrow: got %h want 0059", time_bcd);
        end
        press_stop();
        tests++;
        if (running !== 1'b0 || time_bcd !== 16'h0059) begin
            errors++; $display("FAIL stop_pause: run=%b time=%h want 0/0059", running, time_bcd);
        end
        press_stop();
        tests++;
        if (time_bcd !== 16'h0000) begin
            errors++; $display("FAIL stop_idle: got %h want 0000", time_bcd);
        end
    endtask

    task automatic test_door_pause();
        press_digit(4'd1); press_digit(4'd0);
        press_start();
        cyc(2);
        door_closed = 1'b0;
        cyc(20);
        tests++;
        if (running !== 1'b0 || time_bcd !== 16'h0010) begin
            errors++; $display("FAIL door_pause: run=%b time=%h want 0/0010", running, time_bcd);
        end
        door_closed = 1'b1;
        press_start();
        cyc(1);
        tests++;
        if (running !== 1'b1 || time_bcd !== 16'h0010) begin
            errors++; $display("FAIL resume: run=%b time=%h want 1/0010", running, time_bcd);
        end
        cyc(1);
        tests++;
        if (time_bcd !== 16'h0009) begin
            errors++; $display("FAIL held_ps: got %h want 0009", time_bcd);
        end
        press_clear();
    endtask

    task automatic test_digits();
        for (int i = 0; i < 5; i++) press_digit(4'd9);
        tests++;
        if (time_bcd !== 16'h9999) begin
            errors++; $display("FAIL shift_9999: got %h want 9999", time_bcd);
        end
        press_digit(4'hA);
        tests++;
        if (time_bcd !== 16'h9999) begin
            errors++; $display("FAIL digit_a: got %h want 9999", time_bcd);
        end
        press_clear();
        press_start();
        tests++;
        if (time_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL clear_idle: time=%h run=%b want 0000/0", time_bcd, running);
        end
    endtask

    task automatic test_magnet_off();
        magnet_on = 1'b0;
        press_digit(4'd5);
        press_start();
        cyc(10);
        tests++;
        if (time_bcd !== 16'h0005 || running !== 1'b1) begin
            errors++; $display("FAIL magnet_off: time=%h run=%b want 0005/1", time_bcd, running);
        end
        magnet_on = 1'b1;
        cyc(4);
        tests++;
        if (time_bcd !== 16'h0004) begin
            errors++; $display("FAIL magnet_on: got %h want 0004", time_bcd);
        end
        press_clear();
    endtask

    task automatic test_back_to_back();
        press_digit(4'd9); press_digit(4'd0);
        press_start();
        cyc(4);
        tests++;
        if (time_bcd !== 16'h0089) begin
            errors++; $display("FAIL s_hi_9: got %h want 0089", time_bcd);
        end
        press_clear();
        press_digit(4'd2);
        clearn = 1'b0; startn = 1'b0;
        cyc(1);
        clearn = 1'b1; startn = 1'b1;
        tests++;
        if (time_bcd !== 16'h0000 || running !== 1'b0) begin
            errors++; $display("FAIL clear_start: time=%h run=%b want 0000/0", time_bcd, running);
        end
        press_digit(4'd7);
        press_start();
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        tests++;
        if ({time_bcd, running, timer_done} !== 18'h0) begin
            errors++;
            $display("FAIL rst_run: time=%h run=%b done=%b want 0000/0/0", time_bcd, running,
                     timer_done);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_door_pause();
        test_digits();
        test_magnet_off();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
